fifo_wr_arbiter: RTL and testbench

Write-side arbiter that shares the single write port of the dual-clock FIFO among `NUM_REQ` producers in the `wr_clk` domain. It grants one requester at a time in round-robin order and forwards its beats into the FIFO write port until the requester signals last or the burst limit is reached. It honours FIFO back-pressure, so no beat is dropped or duplicated. It sits directly in front of the FIFO `wr_en`/`din`/`full` pins.

---
 rtl/fifo_wr_arbiter.sv | 106 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin share of one FIFO write port among NUM_REQ wr_clk producers.
// Latency: grant registered one edge after request (one dead cycle), then zero-latency beat forwarding.
// Backpressure: fifo_full drops req_ready and holds the burst; optional FIFO_WR_ARB_PRIO0_EN gives requester 0 fixed priority.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          wr_clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic {IDLE, BURST} state_t;

    state_t        state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] sel_id;
    logic [IW-1:0] next_ptr;
    logic          sel_found;
    logic [7:0]    beat_cnt;
    logic [8:0]    cnt_inc;
    logic          accept;
    logic          burst_end;
    int            idx;

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!sel_found && req_valid[idx]) begin
                sel_found = 1'b1;
                sel_id    = IW'(idx);
            end
        end
`ifdef FIFO_WR_ARB_PRIO0_EN
        if (req_valid[0]) begin
            sel_found = 1'b1;
            sel_id    = '0;
        end
`endif
    end

    assign busy       = (state == BURST);
    assign accept     = busy && req_valid[grant_id] && !fifo_full;
    assign fifo_wr_en = accept;
    assign fifo_din   = busy ? req_data[grant_id*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign cnt_inc    = {1'b0, beat_cnt} + 9'd1;
    assign burst_end  = accept && (req_last[grant_id] || (cnt_inc >= 9'(MAX_BURST)));
    assign next_ptr   = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    always_comb begin
        req_ready = '0;
        if (busy) begin
            req_ready[grant_id] = !fifo_full;
        end
    end

    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        grant_id <= sel_id;
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (accept) begin
                        beat_cnt <= (cnt_inc >= 9'(MAX_BURST)) ? 8'(MAX_BURST) : cnt_inc[7:0];
                    end
                    // Last beat and count limit on the same beat still close only one burst.
                    if (burst_end) begin
                        state <= IDLE;
`ifdef FIFO_WR_ARB_PRIO0_EN
                        if (grant_id != '0) begin
                            rr_ptr <= next_ptr;
                        end
`else
                        rr_ptr <= next_ptr;
`endif
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-requester beat queues drive the DUT, and a negedge
// monitor pops the expected {grant_id, fifo_din} scoreboard on every FIFO write.
module tb_fifo_wr_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 4;
    localparam int IW = 2;

    logic               wr_clk = 1'b0;
    logic               rst    = 1'b1;
    logic [NR-1:0]      req_valid = '0;
    logic [NR*DW-1:0]   req_data  = '0;
    logic [NR-1:0]      req_last  = '0;
    logic [NR-1:0]      req_ready;
    logic               fifo_full = 1'b0;
    logic               fifo_wr_en;
    logic [DW-1:0]      fifo_din;
    logic [IW-1:0]      grant_id;
    logic               busy;

    int checks = 0;
    int errors = 0;

    logic [8:0]         src_q [NR][$];
    logic [IW+DW-1:0]   exp_q [$];
    logic [IW+DW-1:0]   mon_e;
    logic [NR-1:0]      hold = '0;

    logic               s_busy, s_wen;
    logic [IW-1:0]      s_gid;
    logic [NR-1:0]      s_rdy;
    logic [DW-1:0]      s_din;

    int                 rr_ord [5];
    int                 kk [NR];
    logic [24:0]        hist, exp_hist;
    logic [4:0]         hist5;
    logic               acc_wen, acc_rdy, acc_busy, acc_gid_ok;

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .wr_clk     (wr_clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    always #5 wr_clk = ~wr_clk;

    always @(negedge wr_clk) begin
        if (fifo_wr_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected actual id=%0d din=%h required no write", grant_id, fifo_din);
            end else begin
                mon_e = exp_q.pop_front();
                if ({grant_id, fifo_din} !== mon_e) begin
                    errors++;
                    $display("FAIL wr_beat actual id=%0d din=%h required id=%0d din=%h",
                             grant_id, fifo_din, mon_e[IW+DW-1:DW], mon_e[DW-1:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic load(input int r, input logic [7:0] d, input logic l);
        src_q[r].push_back({l, d});
    endtask

    task automatic expect_beat(input int r, input logic [7:0] d);
        exp_q.push_back({r[IW-1:0], d});
    endtask

    task automatic drive_all();
        logic [8:0] b;
        for (int i = 0; i < NR; i++) begin
            if (src_q[i].size() > 0 && !hold[i]) begin
                b = src_q[i][0];
                req_valid[i]         = 1'b1;
                req_data[i*DW +: DW] = b[7:0];
                req_last[i]          = b[8];
            end else begin
                req_valid[i]         = 1'b0;
                req_data[i*DW +: DW] = '0;
                req_last[i]          = 1'b0;
            end
        end
    endtask

    // Snapshot outputs mid-cycle, then retire accepted beats just after the edge.
    task automatic tick();
        logic [NR-1:0] acc;
        @(negedge wr_clk);
        acc    = req_valid & req_ready;
        s_busy = busy;
        s_wen  = fifo_wr_en;
        s_gid  = grant_id;
        s_rdy  = req_ready;
        s_din  = fifo_din;
        @(posedge wr_clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        end
        drive_all();
    endtask

    task automatic drain(input string nm, input int max_cyc);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < max_cyc) begin
            tick();
            n++;
        end
        chk({nm, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        repeat (2) @(negedge wr_clk);
        chk("rst_busy", busy, 0);
        chk("rst_wen", fifo_wr_en, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_din", fifo_din, 0);
        chk("rst_gid", grant_id, 0);
        @(posedge wr_clk);
        #1;
        rst = 1'b0;

        // Single requester, three beats ending on last.
        load(2, 8'hA1, 1'b0); load(2, 8'hA2, 1'b0); load(2, 8'hA3, 1'b1);
        expect_beat(2, 8'hA1); expect_beat(2, 8'hA2); expect_beat(2, 8'hA3);
        drive_all();
        hist5 = '0;
        for (int k = 0; k < 5; k++) begin
            tick();
            hist5[k] = s_wen;
            if (k == 1) chk("t1_grant", s_gid, 2);
        end
        chk("t1_wen_pattern", hist5, 5'b01110);
        chk("t1_drained", exp_q.size(), 0);

        // rr_ptr should now be 3: requester 3 beats requester 1.
        load(1, 8'hB1, 1'b1); load(3, 8'hB3, 1'b1);
        expect_beat(3, 8'hB3); expect_beat(1, 8'hB1);
        drive_all();
        drain("probe", 20);

        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Round-robin fairness with all requesters valid and no last.
`ifdef FIFO_WR_ARB_PRIO0_EN
        rr_ord = '{0, 0, 1, 2, 3};
`else
        rr_ord = '{0, 1, 2, 3, 0};
`endif
        for (int r = 0; r < NR; r++) begin
            kk[r] = 0;
            for (int k = 0; k < ((r == 0) ? 8 : 4); k++) load(r, {r[3:0], k[3:0]}, 1'b0);
        end
        for (int b = 0; b < 5; b++) begin
            for (int j = 0; j < MB; j++) begin
                expect_beat(rr_ord[b], {rr_ord[b][3:0], kk[rr_ord[b]][3:0]});
                kk[rr_ord[b]]++;
            end
        end
        drive_all();
        for (int k = 0; k < 25; k++) begin
            tick();
            hist[k]     = s_wen;
            exp_hist[k] = (k % 5) != 0;
        end
        chk("rr_wen_pattern", hist, exp_hist);
        chk("rr_drained", exp_q.size(), 0);

        // Back-pressure: full for 5 cycles after beat 2; last coincides with MAX_BURST.
        load(1, 8'hC1, 1'b0); load(1, 8'hC2, 1'b0); load(1, 8'hC3, 1'b0); load(1, 8'hC4, 1'b1);
        expect_beat(1, 8'hC1); expect_beat(1, 8'hC2); expect_beat(1, 8'hC3); expect_beat(1, 8'hC4);
        drive_all();
        repeat (3) tick();
        fifo_full = 1'b1;
        acc_wen = 1'b0; acc_rdy = 1'b0; acc_busy = 1'b1;
        repeat (5) begin
            tick();
            acc_wen  = acc_wen | s_wen;
            acc_rdy  = acc_rdy | s_rdy[1];
            acc_busy = acc_busy & s_busy;
        end
        chk("bp_stall_wen", acc_wen, 0);
        chk("bp_stall_ready", acc_rdy, 0);
        chk("bp_stall_busy", acc_busy, 1);
        chk("bp_pending", exp_q.size(), 2);
        fifo_full = 1'b0;
        drain("bp", 20);

        // Valid gap: requester 3 holds the grant while requester 0 waits.
        load(3, 8'hD1, 1'b0); load(3, 8'hD2, 1'b0); load(3, 8'hD3, 1'b1);
        expect_beat(3, 8'hD1); expect_beat(3, 8'hD2); expect_beat(3, 8'hD3); expect_beat(0, 8'hE0);
        drive_all();
        tick();
        load(0, 8'hE0, 1'b1);
        drive_all();
        tick();
        hold[3] = 1'b1;
        drive_all();
        acc_wen = 1'b0; acc_gid_ok = 1'b1; acc_busy = 1'b1;
        repeat (2) begin
            tick();
            acc_wen    = acc_wen | s_wen;
            acc_gid_ok = acc_gid_ok & (s_gid == 2'd3);
            acc_busy   = acc_busy & s_busy;
        end
        chk("gap_wen", acc_wen, 0);
        chk("gap_gid_held", acc_gid_ok, 1);
        chk("gap_busy", acc_busy, 1);
        hold[3] = 1'b0;
        drive_all();
        drain("gap", 20);

        // Reset during beat 2 of a requester-1 burst.
        for (int k = 1; k <= 5; k++) load(1, {4'hF, k[3:0]}, k == 5);
        expect_beat(1, 8'hF1);
        drive_all();
        repeat (2) tick();
        #2;
        chk("rst_mid_pre_wen", fifo_wr_en, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_wen", fifo_wr_en, 0);
        chk("rst_mid_ready", req_ready, 0);
        chk("rst_mid_din", fifo_din, 0);
        tick();
        rst = 1'b0;
        load(0, 8'h0F, 1'b1);
        expect_beat(0, 8'h0F);
        for (int k = 2; k <= 5; k++) expect_beat(1, {4'hF, k[3:0]});
        drive_all();
        repeat (2) tick();
        chk("rst_first_grant", s_gid, 0);
        drain("rst", 30);

        // Requester 0 burst, then requesters 0 and 2 contend.
        load(0, 8'h61, 1'b1);
        expect_beat(0, 8'h61);
        drive_all();
        drain("prio_setup", 20);
        load(0, 8'h70, 1'b1); load(2, 8'h72, 1'b1);
`ifdef FIFO_WR_ARB_PRIO0_EN
        expect_beat(0, 8'h70); expect_beat(2, 8'h72);
`else
        expect_beat(2, 8'h72); expect_beat(0, 8'h70);
`endif
        drive_all();
        drain("prio", 20);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
